// File: rtl/image_downsample_2x.sv
// 2x image downsampler: streams source pixels from a BRAM in 2x2-block order and writes
// either the top-left pixel (mode 0) or the rounded 2x2 average (mode 1) per output pixel.
//
// state | meaning
// IDLE  | waiting for start_in
// READ  | one source read request per cycle
// DRAIN | waiting for in-flight reads to return and be written
// DONE  | one-cycle completion pulse
module image_downsample_2x #(
  parameter int BIT_DEPTH    = 8,
  parameter int OLD_WIDTH    = 64,
  parameter int OLD_HEIGHT   = 64,
  parameter int READ_LATENCY = 2
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic                                         start_in,
  input  logic                                         mode_in,
  output logic [$clog2(OLD_WIDTH*OLD_HEIGHT)-1:0]      ext_read_addr,
  output logic                                         ext_read_addr_valid,
  input  logic [BIT_DEPTH-1:0]                         ext_pixel_in,
  output logic [((OLD_WIDTH*OLD_HEIGHT/4 > 1) ? $clog2(OLD_WIDTH*OLD_HEIGHT/4) : 1)-1:0] ext_write_addr,
  output logic                                         ext_write_valid,
  output logic [BIT_DEPTH-1:0]                         ext_pixel_out,
  output logic                                         busy_out,
  output logic                                         resize_done
);

  localparam int RA_W    = $clog2(OLD_WIDTH*OLD_HEIGHT);
  localparam int NUM_OUT = OLD_WIDTH*OLD_HEIGHT/4;
  localparam int WA_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int NEW_W   = OLD_WIDTH/2;
  localparam int NEW_H   = OLD_HEIGHT/2;
  localparam int NX_W    = (NEW_W > 1) ? $clog2(NEW_W) : 1;
  localparam int NY_W    = (NEW_H > 1) ? $clog2(NEW_H) : 1;
  localparam int ACC_W   = BIT_DEPTH + 2;
  localparam int TOP     = READ_LATENCY - 1;

  localparam logic [NX_W-1:0] NX_LAST    = NX_W'(NEW_W - 1);
  localparam logic [NY_W-1:0] NY_LAST    = NY_W'(NEW_H - 1);
  localparam logic [RA_W-1:0] ROW_STRIDE = RA_W'(OLD_WIDTH);
  localparam logic [WA_W-1:0] OUT_STRIDE = WA_W'(NEW_W);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic            mode_q;
  logic [NX_W-1:0] nx;
  logic [NY_W-1:0] ny;
  logic [1:0]      sub;
  logic [RA_W-1:0] addr_hold;
  logic [ACC_W-1:0] acc;

  logic [READ_LATENCY-1:0] pipe_valid, pipe_first, pipe_last;
  logic [WA_W-1:0]         pipe_tag [READ_LATENCY];

  logic                 wr_valid_q;
  logic [WA_W-1:0]      wr_addr_q;
  logic [BIT_DEPTH-1:0] pixel_q;

  logic            accept, issue, last_req, ret_valid;
  logic [RA_W-1:0] cur_raddr;
  logic [WA_W-1:0] cur_waddr;
  logic [ACC_W-1:0] acc_sum, acc_round;

  // Source coordinate: sub[0] selects the column, sub[1] the row inside the 2x2 block.
  assign cur_raddr = RA_W'({nx, sub[0]}) + RA_W'({ny, sub[1]}) * ROW_STRIDE;
  assign cur_waddr = WA_W'(nx) + WA_W'(ny) * OUT_STRIDE;
  assign last_req  = (nx == NX_LAST) && (ny == NY_LAST) && (!mode_q || sub == 2'd3);

  assign ret_valid = pipe_valid[TOP];
  assign acc_sum   = (pipe_first[TOP] ? '0 : acc) + ACC_W'(ext_pixel_in);
  assign acc_round = acc_sum + ACC_W'(2);

  always_ff @(posedge clk_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next          = state;
    accept              = 1'b0;
    issue               = 1'b0;
    busy_out            = 1'b1;
    resize_done         = 1'b0;
    case (state)
      IDLE: begin
        busy_out = 1'b0;
        if (start_in) begin
          accept     = 1'b1;
          state_next = READ;
        end
      end
      READ: begin
        issue = 1'b1;
        if (last_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (pipe_valid == '0) state_next = DONE;
      end
      DONE: begin
        resize_done = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
    ext_read_addr_valid = issue;
    ext_read_addr       = issue ? cur_raddr : addr_hold;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mode_q     <= 1'b0;
      nx         <= '0;
      ny         <= '0;
      sub        <= '0;
      addr_hold  <= '0;
      acc        <= '0;
      pipe_valid <= '0;
      pipe_first <= '0;
      pipe_last  <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_tag[i] <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      pixel_q    <= '0;
    end else begin
      if (accept) begin
        mode_q <= mode_in;
        nx     <= '0;
        ny     <= '0;
        sub    <= '0;
      end else if (issue && !last_req) begin
        if (mode_q && sub != 2'd3) begin
          sub <= sub + 2'd1;
        end else begin
          sub <= '0;
          if (nx == NX_LAST) begin
            nx <= '0;
            ny <= ny + NY_W'(1);
          end else begin
            nx <= nx + NX_W'(1);
          end
        end
      end

      if (issue) addr_hold <= cur_raddr;

      pipe_valid[0] <= issue;
      pipe_first[0] <= !mode_q || (sub == 2'd0);
      pipe_last[0]  <= !mode_q || (sub == 2'd3);
      pipe_tag[0]   <= cur_waddr;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_first[i] <= pipe_first[i-1];
        pipe_last[i]  <= pipe_last[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end

      if (ret_valid) acc <= acc_sum;

      wr_valid_q <= ret_valid && pipe_last[TOP];
      if (ret_valid && pipe_last[TOP]) begin
        wr_addr_q <= pipe_tag[TOP];
        pixel_q   <= mode_q ? acc_round[ACC_W-1:2] : ext_pixel_in;
      end
    end
  end

  assign ext_write_valid = wr_valid_q;
  assign ext_write_addr  = wr_addr_q;
  assign ext_pixel_out   = pixel_q;

endmodule

// File: tb/tb_image_downsample_2x.sv
// Bench for image_downsample_2x: a 4x4 instance (latency 2) driven from a vector table plus
// corner sequences, and two 8x8 instances (latency 1 and 4) checked against a reference model.
module tb_image_downsample_2x;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // 4x4, latency 2
  logic       start_a, mode_a;
  logic [3:0] rd_addr_a;
  logic       rd_valid_a;
  logic [7:0] pix_in_a;
  logic [1:0] wr_addr_a;
  logic       wr_valid_a;
  logic [7:0] pix_out_a;
  logic       busy_a, done_a;

  image_downsample_2x #(.BIT_DEPTH(8), .OLD_WIDTH(4), .OLD_HEIGHT(4), .READ_LATENCY(2)) dut_a (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_a), .mode_in(mode_a),
    .ext_read_addr(rd_addr_a), .ext_read_addr_valid(rd_valid_a), .ext_pixel_in(pix_in_a),
    .ext_write_addr(wr_addr_a), .ext_write_valid(wr_valid_a), .ext_pixel_out(pix_out_a),
    .busy_out(busy_a), .resize_done(done_a));

  // 8x8, latency 1 and 4, sharing start/mode
  logic       start_bc, mode_bc;
  logic [5:0] rd_addr_b, rd_addr_c;
  logic       rd_valid_b, rd_valid_c;
  logic [7:0] pix_in_b, pix_in_c;
  logic [3:0] wr_addr_b, wr_addr_c;
  logic       wr_valid_b, wr_valid_c;
  logic [7:0] pix_out_b, pix_out_c;
  logic       busy_b, busy_c, done_b, done_c;

  image_downsample_2x #(.BIT_DEPTH(8), .OLD_WIDTH(8), .OLD_HEIGHT(8), .READ_LATENCY(1)) dut_b (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_bc), .mode_in(mode_bc),
    .ext_read_addr(rd_addr_b), .ext_read_addr_valid(rd_valid_b), .ext_pixel_in(pix_in_b),
    .ext_write_addr(wr_addr_b), .ext_write_valid(wr_valid_b), .ext_pixel_out(pix_out_b),
    .busy_out(busy_b), .resize_done(done_b));

  image_downsample_2x #(.BIT_DEPTH(8), .OLD_WIDTH(8), .OLD_HEIGHT(8), .READ_LATENCY(4)) dut_c (
    .clk_in(clk), .rst_in(rst_n), .start_in(start_bc), .mode_in(mode_bc),
    .ext_read_addr(rd_addr_c), .ext_read_addr_valid(rd_valid_c), .ext_pixel_in(pix_in_c),
    .ext_write_addr(wr_addr_c), .ext_write_valid(wr_valid_c), .ext_pixel_out(pix_out_c),
    .busy_out(busy_c), .resize_done(done_c));

  // BRAM models with the matching read latency
  logic [7:0] mem_a [16];
  logic [7:0] img_bc [64];
  logic [7:0] lat_a [2];
  logic [7:0] lat_b;
  logic [7:0] lat_c [4];

  always @(posedge clk) begin
    lat_a[0] <= mem_a[rd_addr_a];
    lat_a[1] <= lat_a[0];
    lat_b    <= img_bc[rd_addr_b];
    lat_c[0] <= img_bc[rd_addr_c];
    for (int i = 1; i < 4; i++) lat_c[i] <= lat_c[i-1];
  end
  assign pix_in_a = lat_a[1];
  assign pix_in_b = lat_b;
  assign pix_in_c = lat_c[3];

  typedef struct { int a; int d; int c; } ev_t;
  typedef ev_t ev_q_t[$];

  ev_q_t wr_q_a, rd_q_a, wr_q_b, rd_q_b, wr_q_c, rd_q_c;
  int done_cnt_a = 0, done_cyc_a = -1, t0_a = 0;
  int done_cnt_b = 0, done_cyc_b = -1, done_cnt_c = 0, done_cyc_c = -1, t0_bc = 0;

  always @(negedge clk) begin
    ev_t e;
    if (rd_valid_a === 1'b1) begin e.a = int'(rd_addr_a); e.d = 0; e.c = cyc - t0_a; rd_q_a.push_back(e); end
    if (wr_valid_a === 1'b1) begin e.a = int'(wr_addr_a); e.d = int'(pix_out_a); e.c = cyc - t0_a; wr_q_a.push_back(e); end
    if (done_a === 1'b1) begin done_cnt_a++; done_cyc_a = cyc - t0_a; end
    if (rd_valid_b === 1'b1) begin e.a = int'(rd_addr_b); e.d = 0; e.c = cyc - t0_bc; rd_q_b.push_back(e); end
    if (wr_valid_b === 1'b1) begin e.a = int'(wr_addr_b); e.d = int'(pix_out_b); e.c = cyc - t0_bc; wr_q_b.push_back(e); end
    if (done_b === 1'b1) begin done_cnt_b++; done_cyc_b = cyc - t0_bc; end
    if (rd_valid_c === 1'b1) begin e.a = int'(rd_addr_c); e.d = 0; e.c = cyc - t0_bc; rd_q_c.push_back(e); end
    if (wr_valid_c === 1'b1) begin e.a = int'(wr_addr_c); e.d = int'(pix_out_c); e.c = cyc - t0_bc; wr_q_c.push_back(e); end
    if (done_c === 1'b1) begin done_cnt_c++; done_cyc_c = cyc - t0_bc; end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int exp_rd[$];
  int exp_px[$];

  task automatic build_rd(input int w, input int h, input bit mode);
    exp_rd.delete();
    for (int ny = 0; ny < h/2; ny++)
      for (int nx = 0; nx < w/2; nx++)
        for (int s = 0; s < (mode ? 4 : 1); s++)
          exp_rd.push_back((2*nx + s%2) + (2*ny + s/2)*w);
  endtask

  task automatic check_pass(input string tag, input ev_q_t wr, input ev_q_t rd, input int dcnt,
                            input int dcyc, input int w, input int h, input bit mode, input int lat);
    int n, r;
    n = w*h/4;
    r = mode ? 4*n : n;
    build_rd(w, h, mode);
    check({tag, " write_count"}, wr.size(), n);
    for (int k = 0; k < wr.size() && k < n; k++) begin
      check($sformatf("%s wr%0d addr", tag, k), wr[k].a, k);
      check($sformatf("%s wr%0d data", tag, k), wr[k].d, exp_px[k]);
    end
    if (wr.size() == n) check({tag, " last_write_cycle"}, wr[n-1].c, r + lat + 1);
    check({tag, " read_count"}, rd.size(), r);
    for (int k = 0; k < rd.size() && k < r; k++)
      check($sformatf("%s rd%0d addr", tag, k), rd[k].a, exp_rd[k]);
    if (rd.size() > 0) begin
      check({tag, " first_read_cycle"}, rd[0].c, 1);
      check({tag, " last_read_cycle"}, rd[rd.size()-1].c, r);
    end
    check({tag, " done_count"}, dcnt, 1);
    check({tag, " done_cycle"}, dcyc, r + lat + 2);
  endtask

  task automatic go_a(input bit mode);
    @(negedge clk);
    wr_q_a.delete(); rd_q_a.delete();
    done_cnt_a = 0; done_cyc_a = -1;
    mode_a = mode; start_a = 1'b1; t0_a = cyc;
    @(negedge clk);
    start_a = 1'b0; mode_a = ~mode;
  endtask

  task automatic wait_a(input int budget);
    for (int i = 0; i < budget && done_cnt_a == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic go_bc(input bit mode);
    @(negedge clk);
    wr_q_b.delete(); rd_q_b.delete(); wr_q_c.delete(); rd_q_c.delete();
    done_cnt_b = 0; done_cyc_b = -1; done_cnt_c = 0; done_cyc_c = -1;
    mode_bc = mode; start_bc = 1'b1; t0_bc = cyc;
    @(negedge clk);
    start_bc = 1'b0; mode_bc = ~mode;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, " rd_addr"}, rd_addr_a, 0);
    check({tag, " rd_valid"}, rd_valid_a, 0);
    check({tag, " wr_addr"}, wr_addr_a, 0);
    check({tag, " wr_valid"}, wr_valid_a, 0);
    check({tag, " pix_out"}, pix_out_a, 0);
    check({tag, " busy"}, busy_a, 0);
    check({tag, " done"}, done_a, 0);
  endtask

  task automatic load_idx_a();
    for (int k = 0; k < 16; k++) mem_a[k] = 8'(k);
  endtask

  task automatic set_exp4(input int e0, input int e1, input int e2, input int e3);
    exp_px.delete();
    exp_px.push_back(e0); exp_px.push_back(e1); exp_px.push_back(e2); exp_px.push_back(e3);
  endtask

  typedef struct {
    bit                mode;
    logic [15:0][7:0]  img;
    logic [3:0][7:0]   exp;
    int                exp_done;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s;

    // Vector table: 4x4 image, latency 2
    for (int k = 0; k < 16; k++) vecs[0].img[k] = 8'(k);
    vecs[0].mode = 1'b0; vecs[0].exp = {8'd10, 8'd8, 8'd2, 8'd0};   vecs[0].exp_done = 8;
    vecs[1].img  = vecs[0].img;
    vecs[1].mode = 1'b1; vecs[1].exp = {8'd13, 8'd11, 8'd5, 8'd3};  vecs[1].exp_done = 20;
    vecs[2].img  = '1;
    vecs[2].mode = 1'b1; vecs[2].exp = '1;                          vecs[2].exp_done = 20;
    vecs[3].img  = '0;
    vecs[3].img[5]  = 8'd2;   vecs[3].img[2]  = 8'd1;   vecs[3].img[8]  = 8'd1;   vecs[3].img[9] = 8'd1;
    vecs[3].img[10] = 8'd255; vecs[3].img[11] = 8'd255; vecs[3].img[14] = 8'd255; vecs[3].img[15] = 8'd254;
    vecs[3].mode = 1'b1; vecs[3].exp = {8'd255, 8'd1, 8'd0, 8'd1};  vecs[3].exp_done = 20;
    vecs[4].img  = vecs[3].img;
    vecs[4].mode = 1'b0; vecs[4].exp = {8'd255, 8'd1, 8'd1, 8'd0};  vecs[4].exp_done = 8;

    rst_n = 1'b0; start_a = 1'b0; mode_a = 1'b0; start_bc = 1'b0; mode_bc = 1'b0;
    for (int k = 0; k < 16; k++) mem_a[k] = 8'h00;
    for (int k = 0; k < 64; k++) img_bc[k] = 8'h00;
    repeat (2) @(negedge clk);
    check_a_zero("reset");
    check("reset busy_b", busy_b, 0);
    check("reset wr_valid_c", wr_valid_c, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 16; k++) mem_a[k] = vecs[i].img[k];
      go_a(vecs[i].mode);
      wait_a(60);
      set_exp4(vecs[i].exp[0], vecs[i].exp[1], vecs[i].exp[2], vecs[i].exp[3]);
      check_pass($sformatf("vec%0d", i), wr_q_a, rd_q_a, done_cnt_a, done_cyc_a, 4, 4, vecs[i].mode, 2);
      check($sformatf("vec%0d done_cycle_table", i), done_cyc_a, vecs[i].exp_done);
      check($sformatf("vec%0d addr_hold", i), rd_addr_a, exp_rd[exp_rd.size()-1]);
      check($sformatf("vec%0d idle_busy", i), busy_a, 0);
    end

    // start pulses at cycles 5 and 9 of a busy pass are ignored
    load_idx_a();
    go_a(1'b1);
    while (cyc - t0_a < 26) begin
      @(negedge clk);
      start_a = ((cyc - t0_a) == 5) || ((cyc - t0_a) == 9);
    end
    start_a = 1'b0;
    wait_a(10);
    set_exp4(3, 5, 11, 13);
    check_pass("busy_start", wr_q_a, rd_q_a, done_cnt_a, done_cyc_a, 4, 4, 1'b1, 2);

    // start in the resize_done cycle is ignored
    go_a(1'b0);
    while (cyc - t0_a < 8) @(negedge clk);
    check("done_start done_visible", done_a, 1);
    start_a = 1'b1; mode_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("done_start busy_c9", busy_a, 0);
    check("done_start rd_valid_c9", rd_valid_a, 0);
    @(negedge clk);
    check("done_start busy_c10", busy_a, 0);
    repeat (2) @(negedge clk);
    set_exp4(0, 2, 8, 10);
    check_pass("done_start", wr_q_a, rd_q_a, done_cnt_a, done_cyc_a, 4, 4, 1'b0, 2);
    repeat (30) @(negedge clk);

    // reset low for one cycle at cycle 6 of a mode 1 pass
    go_a(1'b1);
    while (cyc - t0_a < 6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_a_zero("midreset");
    repeat (25) @(negedge clk);
    check("midreset writes", wr_q_a.size(), 0);
    check("midreset done_count", done_cnt_a, 0);
    go_a(1'b1);
    wait_a(60);
    set_exp4(3, 5, 11, 13);
    check_pass("after_reset", wr_q_a, rd_q_a, done_cnt_a, done_cyc_a, 4, 4, 1'b1, 2);

    // 8x8 random image on latency 1 and 4, both modes
    for (int k = 0; k < 64; k++) img_bc[k] = 8'($urandom_range(0, 255));
    for (int m = 0; m < 2; m++) begin
      go_bc(m[0]);
      for (int i = 0; i < 400 && (done_cnt_b == 0 || done_cnt_c == 0); i++) @(negedge clk);
      repeat (3) @(negedge clk);
      exp_px.delete();
      for (int ny = 0; ny < 4; ny++)
        for (int nx = 0; nx < 4; nx++) begin
          base = 2*nx + 2*ny*8;
          if (m == 0) exp_px.push_back(int'(img_bc[base]));
          else begin
            s = int'(img_bc[base]) + int'(img_bc[base+1]) + int'(img_bc[base+8]) + int'(img_bc[base+9]);
            exp_px.push_back((s + 2) / 4);
          end
        end
      check_pass($sformatf("lat1_m%0d", m), wr_q_b, rd_q_b, done_cnt_b, done_cyc_b, 8, 8, m[0], 1);
      check_pass($sformatf("lat4_m%0d", m), wr_q_c, rd_q_c, done_cnt_c, done_cyc_c, 8, 8, m[0], 4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
